// File: rtl/rs_ooo_station.sv
// Reservation station: buffers dispatched ALU/branch uops, wakes operands from the CDBs
// and issues the oldest ready entry through a registered valid/ready port.
module rs_ooo_station #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [2:0]               disp_op,
    input  logic [6:0]               disp_type,
    input  logic                     disp_op_other,
    input  logic [XLEN-1:0]          disp_pc,
    input  logic [XLEN-1:0]          disp_v1,
    input  logic [XLEN-1:0]          disp_v2,
    input  logic                     disp_q1_valid,
    input  logic                     disp_q2_valid,
    input  logic [ROB_W-1:0]         disp_q1,
    input  logic [ROB_W-1:0]         disp_q2,
    input  logic [ROB_W-1:0]         disp_rob_id,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [2:0]               iss_op,
    output logic [6:0]               iss_type,
    output logic                     iss_op_other,
    output logic [XLEN-1:0]          iss_pc,
    output logic [XLEN-1:0]          iss_v1,
    output logic [XLEN-1:0]          iss_v2,
    output logic [ROB_W-1:0]         iss_rob_id,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] valid_r, q1p_r, q2p_r, other_r;
    logic [2:0]       op_r   [DEPTH];
    logic [6:0]       type_r [DEPTH];
    logic [XLEN-1:0]  pc_r   [DEPTH];
    logic [XLEN-1:0]  v1_r   [DEPTH];
    logic [XLEN-1:0]  v2_r   [DEPTH];
    logic [ROB_W-1:0] q1_r   [DEPTH];
    logic [ROB_W-1:0] q2_r   [DEPTH];
    logic [ROB_W-1:0] rob_r  [DEPTH];
    // older_r[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] older_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic             alive_r;

    logic             iss_valid_r, iss_op_other_r;
    logic [2:0]       iss_op_r;
    logic [6:0]       iss_type_r;
    logic [XLEN-1:0]  iss_pc_r, iss_v1_r, iss_v2_r;
    logic [ROB_W-1:0] iss_rob_id_r;

    logic [XLEN:0]    wk1_s [DEPTH];
    logic [XLEN:0]    wk2_s [DEPTH];
    logic [XLEN:0]    byp1_s, byp2_s;
    logic [DEPTH-1:0] ready_s, sel_oh_s;
    logic [IW-1:0]    sel_idx_s, free_idx_s;
    logic             disp_s, load_s;

    // Returns {hit, value}; scanning from the top bus down lets the lowest matching bus win.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] ids,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] hit;
        hit = {1'b0, {XLEN{1'b0}}};
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            hit = (vld[k] && (ids[k*ROB_W +: ROB_W] == tag)) ? {1'b1, vals[k*XLEN +: XLEN]} : hit;
        end
        return hit;
    endfunction

    assign ready_s    = valid_r & ~q1p_r & ~q2p_r;
    assign disp_ready = alive_r && rdy && (count_r != CW'(DEPTH));
    assign disp_s     = rdy && !flush && disp_valid && disp_ready;
    assign load_s     = rdy && !flush && (|ready_s) && (!iss_valid_r || iss_ready);

    // CDB matches for every stored tag and for the incoming dispatch tags
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1_s[i] = cdb_lookup(q1_r[i], cdb_valid, cdb_rob_id, cdb_value);
            wk2_s[i] = cdb_lookup(q2_r[i], cdb_valid, cdb_rob_id, cdb_value);
        end
        byp1_s = cdb_lookup(disp_q1, cdb_valid, cdb_rob_id, cdb_value);
        byp2_s = cdb_lookup(disp_q2, cdb_valid, cdb_rob_id, cdb_value);
    end

    // Oldest-ready select through the age matrix, and lowest free slot for dispatch
    always_comb begin
        sel_oh_s   = '0;
        sel_idx_s  = '0;
        free_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh_s[i] = ready_s[i];
            for (int j = 0; j < DEPTH; j++) begin
                sel_oh_s[i] = sel_oh_s[i] & ~(ready_s[j] & older_r[j][i]);
            end
            sel_idx_s = sel_idx_s | (sel_oh_s[i] ? IW'(i) : '0);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = valid_r[i] ? free_idx_s : IW'(i);
        end
    end

    // Entry storage: wakeup, free on issue, allocate on dispatch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            q1p_r   <= '0;
            q2p_r   <= '0;
            other_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]    <= 3'd0;
                type_r[i]  <= 7'd0;
                pc_r[i]    <= '0;
                v1_r[i]    <= '0;
                v2_r[i]    <= '0;
                q1_r[i]    <= '0;
                q2_r[i]    <= '0;
                rob_r[i]   <= '0;
                older_r[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                valid_r <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_r[i] && q1p_r[i] && wk1_s[i][XLEN]) begin
                        v1_r[i]  <= wk1_s[i][XLEN-1:0];
                        q1p_r[i] <= 1'b0;
                    end
                    if (valid_r[i] && q2p_r[i] && wk2_s[i][XLEN]) begin
                        v2_r[i]  <= wk2_s[i][XLEN-1:0];
                        q2p_r[i] <= 1'b0;
                    end
                end
                if (load_s) begin
                    valid_r[sel_idx_s] <= 1'b0;
                end
                if (disp_s) begin
                    valid_r[free_idx_s] <= 1'b1;
                    op_r[free_idx_s]    <= disp_op;
                    type_r[free_idx_s]  <= disp_type;
                    other_r[free_idx_s] <= disp_op_other;
                    pc_r[free_idx_s]    <= disp_pc;
                    rob_r[free_idx_s]   <= disp_rob_id;
                    q1_r[free_idx_s]    <= disp_q1;
                    q2_r[free_idx_s]    <= disp_q2;
                    v1_r[free_idx_s]    <= (disp_q1_valid && byp1_s[XLEN]) ? byp1_s[XLEN-1:0] : disp_v1;
                    v2_r[free_idx_s]    <= (disp_q2_valid && byp2_s[XLEN]) ? byp2_s[XLEN-1:0] : disp_v2;
                    q1p_r[free_idx_s]   <= disp_q1_valid && !byp1_s[XLEN];
                    q2p_r[free_idx_s]   <= disp_q2_valid && !byp2_s[XLEN];
                    // New entry is younger than everything present
                    for (int j = 0; j < DEPTH; j++) begin
                        older_r[j][free_idx_s] <= 1'b1;
                    end
                    older_r[free_idx_s] <= '0;
                end
            end
        end
    end

    // Issue register with valid/ready handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_r    <= 1'b0;
            iss_op_r       <= 3'd0;
            iss_type_r     <= 7'd0;
            iss_op_other_r <= 1'b0;
            iss_pc_r       <= '0;
            iss_v1_r       <= '0;
            iss_v2_r       <= '0;
            iss_rob_id_r   <= '0;
        end else if (rdy) begin
            if (flush) begin
                iss_valid_r <= 1'b0;
            end else if (load_s) begin
                iss_valid_r    <= 1'b1;
                iss_op_r       <= op_r[sel_idx_s];
                iss_type_r     <= type_r[sel_idx_s];
                iss_op_other_r <= other_r[sel_idx_s];
                iss_pc_r       <= pc_r[sel_idx_s];
                iss_v1_r       <= v1_r[sel_idx_s];
                iss_v2_r       <= v2_r[sel_idx_s];
                iss_rob_id_r   <= rob_r[sel_idx_s];
            end else if (iss_ready) begin
                iss_valid_r <= 1'b0;
            end
        end
    end

    // Occupancy counter and post-reset dispatch enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (rdy) begin
                count_r <= flush ? '0 : (count_r + {{(CW-1){1'b0}}, disp_s} - {{(CW-1){1'b0}}, load_s});
            end
        end
    end

    assign count        = count_r;
    assign iss_valid    = iss_valid_r;
    assign iss_op       = iss_op_r;
    assign iss_type     = iss_type_r;
    assign iss_op_other = iss_op_other_r;
    assign iss_pc       = iss_pc_r;
    assign iss_v1       = iss_v1_r;
    assign iss_v2       = iss_v2_r;
    assign iss_rob_id   = iss_rob_id_r;

endmodule

// File: tb/tb_rs_ooo_station.sv
// Directed bench for rs_ooo_station: issue latency, wakeup, bypass, backpressure, age order,
// flush, rdy freeze and asynchronous reset.
module tb_rs_ooo_station;
    localparam int DEPTH = 8, NUM_CDB = 2, ROB_W = 4, XLEN = 32;

    logic clk, rst, rdy, flush, disp_valid, disp_ready, disp_op_other;
    logic [2:0] disp_op;
    logic [6:0] disp_type;
    logic [31:0] disp_pc, disp_v1, disp_v2;
    logic disp_q1_valid, disp_q2_valid;
    logic [3:0] disp_q1, disp_q2, disp_rob_id;
    logic [1:0] cdb_valid;
    logic [7:0] cdb_rob_id;
    logic [63:0] cdb_value;
    logic iss_valid, iss_ready, iss_op_other;
    logic [2:0] iss_op;
    logic [6:0] iss_type;
    logic [31:0] iss_pc, iss_v1, iss_v2;
    logic [3:0] iss_rob_id;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;

    rs_ooo_station #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_type(disp_type),
        .disp_op_other(disp_op_other), .disp_pc(disp_pc), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_q1_valid(disp_q1_valid), .disp_q2_valid(disp_q2_valid), .disp_q1(disp_q1),
        .disp_q2(disp_q2), .disp_rob_id(disp_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_type(iss_type),
        .iss_op_other(iss_op_other), .iss_pc(iss_pc), .iss_v1(iss_v1), .iss_v2(iss_v2),
        .iss_rob_id(iss_rob_id), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        flush      = 1'b0;
    endtask

    // Op, opcode class, instr[30] and pc are derived from the rob tag so they can be predicted.
    task automatic disp(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                        input logic q1v, input logic [3:0] q1, input logic q2v, input logic [3:0] q2);
        disp_valid    = 1'b1;
        disp_rob_id   = rob;
        disp_op       = rob[2:0];
        disp_op_other = rob[0];
        disp_type     = {3'b110, rob};
        disp_pc       = 32'h0000_1000 + {26'd0, rob, 2'b00};
        disp_v1       = v1;
        disp_v2       = v2;
        disp_q1_valid = q1v;
        disp_q1       = q1;
        disp_q2_valid = q2v;
        disp_q2       = q2;
    endtask

    task automatic bcast(input int k, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[k]              = 1'b1;
        cdb_rob_id[k*4 +: 4]      = tag;
        cdb_value[k*32 +: 32]     = val;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; iss_ready = 1'b1; cdb_rob_id = 8'd0; cdb_value = 64'd0;
        idle();
        disp(4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        disp_valid = 1'b0;
        step(); step();
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL reset_disp_ready: got %0b expected 0", disp_ready); end
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (iss_v1 !== 32'd0) begin n_errors++; $display("FAIL reset_iss_v1: got %0h expected 0", iss_v1); end
        rst = 1'b1;
        step();
        n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL release_disp_ready: got %0b expected 1", disp_ready); end
    endtask

    task automatic test_basic_issue();
        disp(4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        step(); idle();
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t1_count_after_disp: got %0d expected 1", count); end
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL t1_early_issue: got %0b expected 0", iss_valid); end
        step();
        n_checks++; if (iss_valid !== 1'b1) begin n_errors++; $display("FAIL t1_iss_valid: got %0b expected 1", iss_valid); end
        n_checks++; if (iss_rob_id !== 4'd3) begin n_errors++; $display("FAIL t1_rob: got %0d expected 3", iss_rob_id); end
        n_checks++; if (iss_v1 !== 32'd5 || iss_v2 !== 32'd7) begin n_errors++; $display("FAIL t1_vals: got %0d/%0d expected 5/7", iss_v1, iss_v2); end
        n_checks++; if (iss_op !== 3'd3 || iss_op_other !== 1'b1 || iss_type !== 7'h63) begin n_errors++; $display("FAIL t1_ctl: got op %0d other %0b type %0h expected 3/1/63", iss_op, iss_op_other, iss_type); end
        n_checks++; if (iss_pc !== 32'h0000_100c) begin n_errors++; $display("FAIL t1_pc: got %0h expected 100c", iss_pc); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL t1_count_after_issue: got %0d expected 0", count); end
        step();
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL t1_iss_drop: got %0b expected 0", iss_valid); end
    endtask

    task automatic test_wakeup_order();
        disp(4'd1, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0); step();
        disp(4'd2, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0); step();
        idle();
        n_checks++; if (count !== 4'd2 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL t2_pre: got count %0d valid %0b expected 2/0", count, iss_valid); end
        bcast(1, 4'd9, 32'h10); bcast(0, 4'd5, 32'hdead);
        step(); idle();
        n_checks++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd2) begin n_errors++; $display("FAIL t2_first: got valid %0b rob %0d expected 1/2", iss_valid, iss_rob_id); end
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t2_count: got %0d expected 1", count); end
        step();
        n_checks++; if (iss_rob_id !== 4'd1 || iss_v1 !== 32'h10 || iss_v2 !== 32'd2) begin n_errors++; $display("FAIL t2_second: got rob %0d v1 %0h v2 %0h expected 1/10/2", iss_rob_id, iss_v1, iss_v2); end
        step();
        n_checks++; if (iss_valid !== 1'b0 || count !== 4'd0) begin n_errors++; $display("FAIL t2_empty: got valid %0b count %0d expected 0/0", iss_valid, count); end
    endtask

    task automatic test_bypass();
        disp(4'd6, 32'h11, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4);
        bcast(0, 4'd4, 32'hab); bcast(1, 4'd4, 32'hcd);
        step(); idle();
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t3_count: got %0d expected 1", count); end
        step();
        n_checks++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd6) begin n_errors++; $display("FAIL t3_issue: got valid %0b rob %0d expected 1/6", iss_valid, iss_rob_id); end
        n_checks++; if (iss_v2 !== 32'hab || iss_v1 !== 32'h11) begin n_errors++; $display("FAIL t3_vals: got v1 %0h v2 %0h expected 11/ab", iss_v1, iss_v2); end
        step();
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL t3_drop: got %0b expected 0", iss_valid); end
    endtask

    task automatic test_backpressure();
        iss_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            disp(4'(r), 32'(100 + r), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        end
        idle();
        n_checks++; if (count !== 4'd7 || disp_ready !== 1'b1) begin n_errors++; $display("FAIL t4_seven: got count %0d ready %0b expected 7/1", count, disp_ready); end
        n_checks++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd0) begin n_errors++; $display("FAIL t4_head: got valid %0b rob %0d expected 1/0", iss_valid, iss_rob_id); end
        disp(4'd8, 32'd108, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step(); idle();
        n_checks++; if (count !== 4'd8 || disp_ready !== 1'b0) begin n_errors++; $display("FAIL t4_full: got count %0d ready %0b expected 8/0", count, disp_ready); end
        disp(4'd9, 32'd109, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step(); idle();
        n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL t4_ignored: got count %0d expected 8", count); end
        n_checks++; if (iss_rob_id !== 4'd0 || iss_v1 !== 32'd100) begin n_errors++; $display("FAIL t4_hold: got rob %0d v1 %0d expected 0/100", iss_rob_id, iss_v1); end
        iss_ready = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            step();
            n_checks++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'(r) || count !== 4'(8 - r)) begin n_errors++; $display("FAIL t4_drain_%0d: got valid %0b rob %0d count %0d expected 1/%0d/%0d", r, iss_valid, iss_rob_id, count, r, 8 - r); end
        end
        step();
        n_checks++; if (iss_valid !== 1'b0 || count !== 4'd0) begin n_errors++; $display("FAIL t4_empty: got valid %0b count %0d expected 0/0", iss_valid, count); end
    endtask

    task automatic test_age_order();
        iss_ready = 1'b1;
        disp(4'd1, 32'd0, 32'd1, 1'b1, 4'd13, 1'b0, 4'd0); step();
        disp(4'd2, 32'd0, 32'd2, 1'b1, 4'd13, 1'b0, 4'd0); step();
        disp(4'd3, 32'd0, 32'd3, 1'b1, 4'd12, 1'b0, 4'd0); step();
        disp(4'd4, 32'd0, 32'd4, 1'b1, 4'd12, 1'b0, 4'd0); step();
        disp(4'd5, 32'd0, 32'd5, 1'b1, 4'd12, 1'b0, 4'd0); step();
        idle();
        n_checks++; if (count !== 4'd5 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL t5_filled: got count %0d valid %0b expected 5/0", count, iss_valid); end
        bcast(0, 4'd13, 32'h55); step(); idle();
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL t5_wake_latency: got %0b expected 0", iss_valid); end
        step();
        n_checks++; if (iss_rob_id !== 4'd1 || iss_v1 !== 32'h55 || count !== 4'd4) begin n_errors++; $display("FAIL t5_a: got rob %0d v1 %0h count %0d expected 1/55/4", iss_rob_id, iss_v1, count); end
        disp(4'd6, 32'h66, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0);
        bcast(0, 4'd12, 32'h77); bcast(1, 4'd12, 32'h99);
        step(); idle();
        n_checks++; if (iss_rob_id !== 4'd2 || count !== 4'd4) begin n_errors++; $display("FAIL t5_b: got rob %0d count %0d expected 2/4", iss_rob_id, count); end
        disp(4'd7, 32'h67, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0); step(); idle();
        n_checks++; if (iss_rob_id !== 4'd3 || iss_v1 !== 32'h77 || count !== 4'd4) begin n_errors++; $display("FAIL t5_c: got rob %0d v1 %0h count %0d expected 3/77/4", iss_rob_id, iss_v1, count); end
        for (int r = 4; r <= 7; r++) begin
            step();
            n_checks++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'(r) || count !== 4'(7 - r)) begin n_errors++; $display("FAIL t5_order_%0d: got valid %0b rob %0d count %0d expected 1/%0d/%0d", r, iss_valid, iss_rob_id, count, r, 7 - r); end
        end
        step();
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL t5_empty: got %0b expected 0", iss_valid); end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            disp(4'(r), 32'(r), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        end
        idle();
        n_checks++; if (count !== 4'd6 || iss_valid !== 1'b1 || iss_rob_id !== 4'd1) begin n_errors++; $display("FAIL t6_pre: got count %0d valid %0b rob %0d expected 6/1/1", count, iss_valid, iss_rob_id); end
        flush = 1'b1; iss_ready = 1'b1;
        disp(4'd9, 32'd9, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step(); idle();
        n_checks++; if (count !== 4'd0 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL t6_flush: got count %0d valid %0b expected 0/0", count, iss_valid); end
        step();
        n_checks++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin n_errors++; $display("FAIL t6_dropped: got count %0d valid %0b ready %0b expected 0/0/1", count, iss_valid, disp_ready); end
    endtask

    task automatic test_rdy_freeze();
        iss_ready = 1'b0;
        disp(4'd10, 32'ha0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        disp(4'd11, 32'ha1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        idle();
        n_checks++; if (iss_rob_id !== 4'd10 || count !== 4'd1) begin n_errors++; $display("FAIL frz_pre: got rob %0d count %0d expected 10/1", iss_rob_id, count); end
        rdy = 1'b0; flush = 1'b1; iss_ready = 1'b1;
        disp(4'd12, 32'ha2, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL frz_disp_ready: got %0b expected 0", disp_ready); end
        step();
        n_checks++; if (count !== 4'd1 || iss_valid !== 1'b1 || iss_rob_id !== 4'd10) begin n_errors++; $display("FAIL frz_hold: got count %0d valid %0b rob %0d expected 1/1/10", count, iss_valid, iss_rob_id); end
        rdy = 1'b1; idle();
        step();
        n_checks++; if (iss_rob_id !== 4'd11 || count !== 4'd0) begin n_errors++; $display("FAIL frz_resume: got rob %0d count %0d expected 11/0", iss_rob_id, count); end
        step();
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL frz_empty: got %0b expected 0", iss_valid); end
    endtask

    task automatic test_async_reset();
        iss_ready = 1'b0;
        disp(4'd13, 32'hb0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        disp(4'd14, 32'hb1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0); step();
        idle();
        n_checks++; if (iss_valid !== 1'b1 || count !== 4'd1) begin n_errors++; $display("FAIL ar_pre: got valid %0b count %0d expected 1/1", iss_valid, count); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (iss_valid !== 1'b0 || count !== 4'd0 || disp_ready !== 1'b0) begin n_errors++; $display("FAIL ar_clear: got valid %0b count %0d ready %0b expected 0/0/0", iss_valid, count, disp_ready); end
        n_checks++; if (iss_rob_id !== 4'd0 || iss_v1 !== 32'd0) begin n_errors++; $display("FAIL ar_data: got rob %0d v1 %0h expected 0/0", iss_rob_id, iss_v1); end
        rst = 1'b1;
        step();
        n_checks++; if (disp_ready !== 1'b1 || count !== 4'd0) begin n_errors++; $display("FAIL ar_release: got ready %0b count %0d expected 1/0", disp_ready, count); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup_order();
        test_bypass();
        test_backpressure();
        test_age_order();
        test_flush();
        test_rdy_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
